pwm_ctrl: RTL and testbench
===========================

Name: pwm_ctrl

Overview:
- Memory-mapped control stage directly upstream of the pulse generator.
- Holds the software-visible PWM registers and drives the generator's enable, period and duty inputs, plus a counter-clear strobe.
- Keeps a lockstep period counter so period and duty changes apply only at period boundaries (glitch-free).
- Supports free-running and N-period burst modes, with a done flag and an interrupt.

Parameters:
- CNT_W, 32, width of period/duty/count registers and of the mirror counter.
- NUM_W, 16, width of burst-length register and periods-done counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- we_i  in  1  register write strobe, one cycle per write
- addr_i  in  8  byte address; only [4:2] decoded
- data_i  in  32  write data
- data_o  out  32  read data, combinational from addr_i
- en_o  out  1  generator enable
- freq_cnt_o  out  CNT_W  active period (cycles)
- duty_cnt_o  out  CNT_W  active duty (cycles high)
- gen_rst_n_o  out  1  active-low generator counter clear
- irq_o  out  1  level interrupt = STATUS.done & CTRL.irq_en

Behaviour:
- Register map:
  - 0x00 CTRL: [0] start, [1] burst, [2] irq_en.
  - 0x04 PERIOD.
  - 0x08 DUTY.
  - 0x0C NUM, burst length.
  - 0x10 STATUS: [0] busy, RO; [1] done, W1C.
  - 0x14 PCNT, periods done, RO.
  - Other addresses read 0; writes to them are ignored.
- Shadow registers: software writes land in PERIOD_s/DUTY_s. The active freq_cnt_o/duty_cnt_o load from them:
  - in IDLE and START, every cycle;
  - in RUN, only in the boundary cycle (mirror == freq_cnt_o-1, en_o=1), with the new values effective from the next cycle.
- Reset values: all registers 0; state IDLE; en_o=0; freq_cnt_o=0; duty_cnt_o=0; gen_rst_n_o=1; irq_o=0; data_o follows addr.
- FSM states: IDLE, START, RUN.
- IDLE:
  - A write to CTRL with bit0=1 and PERIOD_s != 0 -> START.
  - If PERIOD_s == 0, the start is ignored and CTRL.start reads back 0.
- START (exactly one cycle):
  - gen_rst_n_o=0, en_o=0; mirror counter and PCNT cleared; done cleared.
  - Next state RUN.
- RUN:
  - en_o=1.
  - Mirror counter increments; it wraps to 0 at freq_cnt_o-1.
  - Each boundary increments PCNT; PCNT saturates at all-ones.
  - If burst=1, NUM != 0 and PCNT == NUM-1 at a boundary:
    - next state IDLE, with en_o low from the next cycle;
    - done set, CTRL.start cleared.
  - burst=1 with NUM=0 behaves as free-running.
  - A CTRL write with bit0=0 -> IDLE next cycle; the partial period is abandoned and done is not set.
  - A CTRL write with bit0=1 while in RUN only updates burst/irq_en; there is no restart.
- Latency: the CTRL start write in cycle T gives gen_rst_n_o low in T+1 and en_o high in T+2. The generator's first high cycle is T+2 if duty > 0.
- Duty >= period: output is constantly high. Duty 0: constantly low. Both are legal and need no special case here.
- Shadow write in the same cycle as a boundary: the boundary load takes the new value (write-through).
- busy = (state != IDLE).
- STATUS done W1C in the same cycle as a set: the set wins.
- Synchronous reset mid-operation returns everything to reset values next cycle, including gen_rst_n_o=1, en_o=0.
- Widths: comparisons are unsigned CNT_W; freq_cnt_o-1 is computed only when freq_cnt_o != 0, which is guaranteed in RUN.

Decomposition:
- Shared package/header holds:
  - register offsets: CTRL, PERIOD, DUTY, NUM, STATUS, PCNT;
  - CTRL/STATUS bit indices;
  - FSM state encodings.
- One natural sub-module: pwm_period_tracker, containing the mirror counter, boundary detect and PCNT saturating counter. The register file and FSM stay in pwm_ctrl.

Test Plan:
- Reset, then read all addresses -> all 0; en_o=0, gen_rst_n_o=1, irq_o=0.
- PERIOD=10, DUTY=3, CTRL=1 at cycle T -> gen_rst_n_o=0 at T+1; en_o=1 from T+2; PCNT=1 after 10 RUN cycles.
- RUN with PERIOD=10, write DUTY=7 at mirror=4 -> duty_cnt_o stays 3 until the boundary (mirror=9), then reads 7; no mid-period change.
- Burst: PERIOD=4, NUM=3, CTRL=0b111 -> en_o high exactly 12 cycles; then STATUS=0b10, irq_o=1, CTRL.start=0. W1C to STATUS[1] -> irq_o=0.
- Mid-run CTRL=0 at mirror=2 -> en_o=0 next cycle, done=0. Restart -> a fresh START pulse, PCNT=0.
- CTRL=1 with PERIOD=0 -> stays IDLE, busy=0, en_o=0.
- rst asserted during RUN -> next cycle all outputs and registers at reset values.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM control stage: register indices,
// CTRL/STATUS bit positions and FSM state encodings.
package pwm_ctrl_pkg;

    // Word index taken from addr[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PERIOD = 3'd1;
    localparam logic [2:0] REG_DUTY   = 3'd2;
    localparam logic [2:0] REG_NUM    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_PCNT   = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_BURST  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } pwm_state_t;

    function automatic logic [2:0] reg_index(input logic [7:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/pwm_period_tracker.sv
// Lockstep mirror of the generator's period counter: flags the last cycle of
// each period and counts completed periods with saturation.
module pwm_period_tracker
    import pwm_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] freq_cnt,
    output logic             boundary,
    output logic [NUM_W-1:0] pcnt
);

    logic [CNT_W-1:0] mirror_r;
    logic [CNT_W-1:0] last_s;
    logic             boundary_s;
    logic [NUM_W-1:0] pcnt_r;

    // Terminal count of the active period; a zero period never matches.
    always_comb begin
        last_s     = {CNT_W{1'b0}};
        boundary_s = 1'b0;
        if (freq_cnt != {CNT_W{1'b0}}) begin
            last_s     = freq_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            boundary_s = run && (mirror_r == last_s);
        end else begin
            last_s     = {CNT_W{1'b0}};
            boundary_s = 1'b0;
        end
    end

    // Mirror counter: cleared on start, advances only while the generator runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mirror_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            mirror_r <= {CNT_W{1'b0}};
        end else if (boundary_s) begin
            mirror_r <= {CNT_W{1'b0}};
        end else if (run) begin
            mirror_r <= mirror_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            mirror_r <= mirror_r;
        end
    end

    // Completed-period counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_r <= {NUM_W{1'b0}};
        end else if (clear) begin
            pcnt_r <= {NUM_W{1'b0}};
        end else if (boundary_s && (pcnt_r != {NUM_W{1'b1}})) begin
            pcnt_r <= pcnt_r + {{(NUM_W-1){1'b0}}, 1'b1};
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

    assign boundary = boundary_s;
    assign pcnt     = pcnt_r;

endmodule

// File: rtl/pwm_ctrl.sv
// Memory-mapped PWM control stage: register file, start/run FSM and
// boundary-synchronised period/duty hand-off to the pulse generator.
module pwm_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [7:0]       addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    output logic             en_o,
    output logic [CNT_W-1:0] freq_cnt_o,
    output logic [CNT_W-1:0] duty_cnt_o,
    output logic             gen_rst_n_o,
    output logic             irq_o
);

    pwm_state_t       state_r, state_nxt_s;
    logic             start_r, start_nxt_s;
    logic             burst_r, burst_nxt_s;
    logic             irq_en_r, irq_en_nxt_s;
    logic             done_r, done_nxt_s;
    logic [CNT_W-1:0] period_r, period_nxt_s;
    logic [CNT_W-1:0] duty_r, duty_nxt_s;
    logic [NUM_W-1:0] num_r;
    logic [2:0]       idx_s;
    logic             wr_ctrl_s, wr_period_s, wr_duty_s, wr_num_s, wr_status_s;
    logic             stop_s, burst_end_s, load_s, boundary_s;
    logic [NUM_W-1:0] pcnt_s;
    logic             unused_addr_s;

    assign idx_s         = reg_index(addr_i);
    assign unused_addr_s = ^{addr_i[7:5], addr_i[1:0]};
    assign wr_ctrl_s     = we_i && (idx_s == REG_CTRL);
    assign wr_period_s   = we_i && (idx_s == REG_PERIOD);
    assign wr_duty_s     = we_i && (idx_s == REG_DUTY);
    assign wr_num_s      = we_i && (idx_s == REG_NUM);
    assign wr_status_s   = we_i && (idx_s == REG_STATUS);
    assign stop_s        = wr_ctrl_s && !data_i[CTRL_START];

    assign period_nxt_s = wr_period_s ? data_i[CNT_W-1:0] : period_r;
    assign duty_nxt_s   = wr_duty_s ? data_i[CNT_W-1:0] : duty_r;
    // Write-through: a boundary coinciding with a shadow write takes the new value.
    assign load_s       = (state_r != ST_RUN) || boundary_s;
    assign burst_end_s  = boundary_s && burst_r && (num_r != {NUM_W{1'b0}})
                          && (pcnt_s == (num_r - {{(NUM_W-1){1'b0}}, 1'b1}));

    pwm_period_tracker #(
        .CNT_W (CNT_W),
        .NUM_W (NUM_W)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_r == ST_START),
        .run      (en_o),
        .freq_cnt (freq_cnt_o),
        .boundary (boundary_s),
        .pcnt     (pcnt_s)
    );

    // Next-state and CTRL/STATUS next values; done W1C is overridden by a set.
    always_comb begin
        state_nxt_s  = state_r;
        start_nxt_s  = start_r;
        burst_nxt_s  = burst_r;
        irq_en_nxt_s = irq_en_r;
        done_nxt_s   = done_r;
        if (wr_ctrl_s) begin
            burst_nxt_s  = data_i[CTRL_BURST];
            irq_en_nxt_s = data_i[CTRL_IRQ_EN];
        end else begin
            burst_nxt_s  = burst_r;
            irq_en_nxt_s = irq_en_r;
        end
        if (wr_status_s && data_i[STAT_DONE]) begin
            done_nxt_s = 1'b0;
        end else begin
            done_nxt_s = done_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (wr_ctrl_s && data_i[CTRL_START] && (period_r != {CNT_W{1'b0}})) begin
                    state_nxt_s = ST_START;
                    start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    start_nxt_s = 1'b0;
                end
            end
            ST_START: begin
                done_nxt_s = 1'b0;
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                    start_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_RUN;
                    start_nxt_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                    start_nxt_s = 1'b0;
                end else if (burst_end_s) begin
                    state_nxt_s = ST_IDLE;
                    start_nxt_s = 1'b0;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                    start_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                start_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Software registers and generator-facing outputs, all derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_r     <= 1'b0;
            burst_r     <= 1'b0;
            irq_en_r    <= 1'b0;
            done_r      <= 1'b0;
            period_r    <= {CNT_W{1'b0}};
            duty_r      <= {CNT_W{1'b0}};
            num_r       <= {NUM_W{1'b0}};
            freq_cnt_o  <= {CNT_W{1'b0}};
            duty_cnt_o  <= {CNT_W{1'b0}};
            en_o        <= 1'b0;
            gen_rst_n_o <= 1'b1;
            irq_o       <= 1'b0;
        end else begin
            start_r     <= start_nxt_s;
            burst_r     <= burst_nxt_s;
            irq_en_r    <= irq_en_nxt_s;
            done_r      <= done_nxt_s;
            period_r    <= period_nxt_s;
            duty_r      <= duty_nxt_s;
            num_r       <= wr_num_s ? data_i[NUM_W-1:0] : num_r;
            freq_cnt_o  <= load_s ? period_nxt_s : freq_cnt_o;
            duty_cnt_o  <= load_s ? duty_nxt_s : duty_cnt_o;
            en_o        <= (state_nxt_s == ST_RUN);
            gen_rst_n_o <= (state_nxt_s != ST_START);
            irq_o       <= done_nxt_s & irq_en_nxt_s;
        end
    end

    // Read mux, combinational from the address.
    always_comb begin
        data_o = 32'd0;
        case (idx_s)
            REG_CTRL:   data_o = {29'd0, irq_en_r, burst_r, start_r};
            REG_PERIOD: data_o = 32'(period_r);
            REG_DUTY:   data_o = 32'(duty_r);
            REG_NUM:    data_o = 32'(num_r);
            REG_STATUS: data_o = {30'd0, done_r, (state_r != ST_IDLE)};
            REG_PCNT:   data_o = 32'(pcnt_s);
            default:    data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_pwm_ctrl.sv
// Directed bench for pwm_ctrl: a vector table for reset/start latency, then
// hand-written sequences for shadow timing, stop/restart, burst and reset.
module tb_pwm_ctrl;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        en_o;
    logic [31:0] freq_cnt_o;
    logic [31:0] duty_cnt_o;
    logic        gen_rst_n_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    pwm_ctrl #(.CNT_W(32), .NUM_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .en_o        (en_o),
        .freq_cnt_o  (freq_cnt_o),
        .duty_cnt_o  (duty_cnt_o),
        .gen_rst_n_o (gen_rst_n_o),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] rd;
        logic        en;
        logic        grn;
        logic        irq;
        logic [31:0] freq;
        logic [31:0] duty;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic we, input logic [7:0] a, input logic [31:0] d,
                                input logic [31:0] rd, input logic en, input logic grn,
                                input logic [31:0] fr, input logic [31:0] du);
        vec_t v;
        v.we = we; v.addr = a; v.data = d; v.rd = rd; v.en = en;
        v.grn = grn; v.irq = 1'b0; v.freq = fr; v.duty = du;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge; outputs settle 1 time unit later.
    task automatic tick(input logic we, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        we_i = we; addr_i = a; data_i = d;
        #1;
    endtask

    int en_cnt;

    initial begin
        rst = 1'b1; we_i = 1'b0; addr_i = 8'h00; data_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset reads, then PERIOD=10, DUTY=3, CTRL=1 at row 9 (cycle T).
        vecs[0]  = mk(1'b0, 8'h00, 32'd0,  32'd0, 1'b0, 1'b1, 32'd0,  32'd0);
        vecs[1]  = mk(1'b0, 8'h04, 32'd0,  32'd0, 1'b0, 1'b1, 32'd0,  32'd0);
        vecs[2]  = mk(1'b0, 8'h08, 32'd0,  32'd0, 1'b0, 1'b1, 32'd0,  32'd0);
        vecs[3]  = mk(1'b0, 8'h0C, 32'd0,  32'd0, 1'b0, 1'b1, 32'd0,  32'd0);
        vecs[4]  = mk(1'b0, 8'h10, 32'd0,  32'd0, 1'b0, 1'b1, 32'd0,  32'd0);
        vecs[5]  = mk(1'b0, 8'h14, 32'd0,  32'd0, 1'b0, 1'b1, 32'd0,  32'd0);
        vecs[6]  = mk(1'b0, 8'h18, 32'd0,  32'd0, 1'b0, 1'b1, 32'd0,  32'd0);
        vecs[7]  = mk(1'b1, 8'h04, 32'd10, 32'd0, 1'b0, 1'b1, 32'd0,  32'd0);
        vecs[8]  = mk(1'b1, 8'h08, 32'd3,  32'd0, 1'b0, 1'b1, 32'd10, 32'd0);
        vecs[9]  = mk(1'b1, 8'h00, 32'd1,  32'd0, 1'b0, 1'b1, 32'd10, 32'd3);
        vecs[10] = mk(1'b0, 8'h10, 32'd0,  32'd1, 1'b0, 1'b0, 32'd10, 32'd3);
        vecs[11] = mk(1'b0, 8'h00, 32'd0,  32'd1, 1'b1, 1'b1, 32'd10, 32'd3);
        for (int i = 12; i < 21; i++) begin
            vecs[i] = mk(1'b0, 8'h14, 32'd0, 32'd0, 1'b1, 1'b1, 32'd10, 32'd3);
        end
        vecs[21] = mk(1'b0, 8'h14, 32'd0, 32'd1, 1'b1, 1'b1, 32'd10, 32'd3);

        for (int i = 0; i < 22; i++) begin
            tick(vecs[i].we, vecs[i].addr, vecs[i].data);
            check($sformatf("v%0d data_o", i), data_o, vecs[i].rd);
            check($sformatf("v%0d en_o", i), 32'(en_o), 32'(vecs[i].en));
            check($sformatf("v%0d gen_rst_n_o", i), 32'(gen_rst_n_o), 32'(vecs[i].grn));
            check($sformatf("v%0d irq_o", i), 32'(irq_o), 32'(vecs[i].irq));
            check($sformatf("v%0d freq_cnt_o", i), freq_cnt_o, vecs[i].freq);
            check($sformatf("v%0d duty_cnt_o", i), duty_cnt_o, vecs[i].duty);
        end

        // Duty change at mirror=4 (T+16) takes effect only after the boundary at T+21.
        repeat (3) tick(1'b0, 8'h14, 32'd0);
        tick(1'b1, 8'h08, 32'd7);
        check("duty at write", duty_cnt_o, 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 8'h08, 32'd0);
            check("duty held mid-period", duty_cnt_o, 32'd3);
            check("duty shadow", data_o, 32'd7);
        end
        tick(1'b0, 8'h08, 32'd0);
        check("duty after boundary", duty_cnt_o, 32'd7);

        // Stop at mirror=2, then restart.
        tick(1'b0, 8'h10, 32'd0);
        tick(1'b1, 8'h00, 32'd0);
        check("en before stop", 32'(en_o), 32'd1);
        tick(1'b0, 8'h10, 32'd0);
        check("en after stop", 32'(en_o), 32'd0);
        check("status after stop", data_o, 32'd0);
        tick(1'b0, 8'h14, 32'd0);
        check("pcnt after stop", data_o, 32'd2);
        tick(1'b1, 8'h00, 32'd1);
        tick(1'b0, 8'h14, 32'd0);
        check("restart gen_rst_n", 32'(gen_rst_n_o), 32'd0);
        check("restart en in start", 32'(en_o), 32'd0);
        tick(1'b0, 8'h14, 32'd0);
        check("restart en", 32'(en_o), 32'd1);
        check("restart pcnt", data_o, 32'd0);
        tick(1'b1, 8'h00, 32'd0);
        tick(1'b0, 8'h10, 32'd0);
        check("stopped busy", data_o, 32'd0);

        // Burst of 3 periods of 4 cycles with interrupt enabled.
        tick(1'b1, 8'h04, 32'd4);
        tick(1'b1, 8'h0C, 32'd3);
        tick(1'b1, 8'h00, 32'd7);
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 8'h10, 32'd0);
            if (en_o) en_cnt++;
        end
        check("burst en cycles", 32'(en_cnt), 32'd12);
        check("burst status", data_o, 32'd2);
        check("burst irq", 32'(irq_o), 32'd1);
        tick(1'b0, 8'h00, 32'd0);
        check("burst ctrl", data_o, 32'd6);
        tick(1'b0, 8'h14, 32'd0);
        check("burst pcnt", data_o, 32'd3);
        tick(1'b1, 8'h10, 32'd2);
        check("irq before w1c", 32'(irq_o), 32'd1);
        tick(1'b0, 8'h10, 32'd0);
        check("irq after w1c", 32'(irq_o), 32'd0);
        check("status after w1c", data_o, 32'd0);

        // Start with PERIOD=0 is ignored.
        tick(1'b1, 8'h04, 32'd0);
        tick(1'b1, 8'h00, 32'd1);
        tick(1'b0, 8'h10, 32'd0);
        check("p0 busy", data_o, 32'd0);
        check("p0 gen_rst_n", 32'(gen_rst_n_o), 32'd1);
        tick(1'b0, 8'h00, 32'd0);
        check("p0 ctrl", data_o, 32'd0);
        check("p0 en", 32'(en_o), 32'd0);

        // Synchronous reset during RUN.
        tick(1'b1, 8'h04, 32'd5);
        tick(1'b1, 8'h08, 32'd2);
        tick(1'b1, 8'h00, 32'd5);
        repeat (4) tick(1'b0, 8'h10, 32'd0);
        check("pre-reset busy", data_o, 32'd1);
        check("pre-reset en", 32'(en_o), 32'd1);
        @(negedge clk);
        rst = 1'b1; we_i = 1'b0; addr_i = 8'h00; data_i = 32'd0;
        @(negedge clk);
        #1;
        check("rst en", 32'(en_o), 32'd0);
        check("rst gen_rst_n", 32'(gen_rst_n_o), 32'd1);
        check("rst freq", freq_cnt_o, 32'd0);
        check("rst duty", duty_cnt_o, 32'd0);
        check("rst irq", 32'(irq_o), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 8'(i * 4), 32'd0);
            check($sformatf("rst read 0x%0h", i * 4), data_o, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
